wb_mem_arbiter: RTL and testbench
=================================

# wb_mem_arbiter

Round-robin Wishbone B3 arbiter that shares the single main-RAM slave port between the OR1200 instruction master, OR1200 data master and the JTAG debug master. It sits between the three masters and `ram_wb_b3` in the SoC top level, replacing a direct point-to-point hookup. Ownership is held for a whole `cyc` (including incrementing bursts), and a per-transfer watchdog terminates hung accesses with `err`.

## Interface

Parameters:
- `num_masters`, 3: number of requesting masters. Index 0 = or1200_i, 1 = or1200_d, 2 = dbg.
- `aw`, 32: address width.
- `dw`, 32: data width. Select width is `dw/8`.
- `timeout`, 255: watchdog limit in cycles, 8-bit. 0 disables the watchdog.

Ports. Master-side vectors are flattened, with master *k* in slice *k*:
- `wb_clk_i` in 1: single clock for everything.
- `wb_rst_ni` in 1: reset, synchronous, active-low.
- `m_adr_i` in `num_masters*aw`: master addresses.
- `m_dat_i` in `num_masters*dw`: master write data.
- `m_sel_i` in `num_masters*dw/8`: master byte selects.
- `m_we_i`, `m_cyc_i`, `m_stb_i` in `num_masters`: master controls.
- `m_cti_i` in `num_masters*3`: master cycle type.
- `m_bte_i` in `num_masters*2`: master burst type.
- `m_dat_o` out `dw`: slave read data, broadcast to all masters.
- `m_ack_o`, `m_err_o`, `m_rty_o` out `num_masters`: terminations. Only the granted bit can be 1.
- `s_adr_o` out `aw`, `s_dat_o` out `dw`, `s_sel_o` out `dw/8`: slave-side address, write data, selects.
- `s_we_o`, `s_cyc_o`, `s_stb_o` out 1: slave-side controls.
- `s_cti_o` out 3, `s_bte_o` out 2: slave-side cycle and burst type.
- `s_dat_i` in `dw`: slave read data.
- `s_ack_i`, `s_err_i`, `s_rty_i` in 1: slave terminations.
- `grant_o` out `num_masters`: one-hot current owner, all zero when idle.
- `timeout_o` out 1: one-cycle pulse when the watchdog fires.

## Operation

- FSM states:
  - IDLE: no owner; `grant_o`=0; `s_cyc_o`=`s_stb_o`=0.
  - OWN: registered one-hot grant.
- IDLE -> OWN:
  - Taken when any `m_cyc_i` bit is 1.
  - The winner is the first requester found scanning from `last+1` upward, modulo `num_masters`.
  - The winner is stored in `grant_o`, and `last` is updated to its index.
- OWN -> IDLE: taken when the granted master's `m_cyc_i` is 0. Requests from other masters are ignored while in OWN; there is no preemption.
- Slave-bound signals in OWN:
  - `s_*_o` is a combinational mux of the granted master's `m_*_i`.
  - `s_cyc_o` = granted `m_cyc_i`.
  - `s_stb_o` = granted `m_stb_i` AND NOT `wd_fire`.
- Master-bound signals:
  - `m_ack_o[g]`=`s_ack_i`, `m_err_o[g]`=`s_err_i | wd_fire`, `m_rty_o[g]`=`s_rty_i` for the granted index g.
  - Non-granted master bits are 0.
  - `m_dat_o`=`s_dat_i`, unqualified.
- Bursts: `cti` 3'b010 beats stay with the owner because `cyc` remains high. An end-of-burst (`cti`=3'b111) has no special handling; release is by `cyc` only.
- Watchdog:
  - 8-bit counter `wd`. It resets to 0 on any termination (`s_ack_i|s_err_i|s_rty_i`), when `s_stb_o`=0, and in IDLE.
  - Otherwise it increments by 1 each cycle. It saturates and never wraps.
  - `wd_fire` = (`timeout`!=0) && (`wd`==`timeout`-1) && `s_stb_o_raw` && no slave termination in that cycle.
  - On `wd_fire`: `m_err_o[g]`=1 for that cycle, `s_stb_o` is forced low for that cycle, `timeout_o`=1, and `wd` is cleared.
- A slave termination in the same cycle as the watchdog limit is a valid termination. In that case `wd_fire`=0 and the slave result is passed through.

## Timing

- Reset, when `wb_rst_ni`=0 at a `wb_clk_i` edge:
  - State IDLE, `grant_o`=0, `last`=`num_masters-1` (master 0 wins first), `wd`=0.
  - All `m_ack_o`/`m_err_o`/`m_rty_o`=0, `s_cyc_o`=`s_stb_o`=0, `timeout_o`=0.
- Reset during OWN drops `s_cyc_o` on the following cycle. No termination is sent to the owner.
- Grant latency: the request is seen in cycle N, `grant_o` and `s_cyc_o` are valid in N+1. A master already requesting at N+1 is presented to the slave with zero further delay.
- Release: the owner drops `cyc` in cycle M, giving IDLE at M+1 and a new owner at M+2. There is exactly one dead cycle between owners.
- Simultaneous requests in the same cycle are resolved by round-robin order only.
- The data path is combinational from the registered grant. There are no pipeline registers, and ack timing is identical to a direct connection.

## Test plan

1. Reset, then only m1 raises `cyc`/`stb` with `adr`=0x100, write 0xDEADBEEF. Required: `grant_o`=3'b010 one cycle later; the slave sees `s_adr_o`=0x100 and `s_dat_o`=0xDEADBEEF; `m_ack_o`=3'b010 on `s_ack_i`.
2. All three raise `cyc` in the same cycle, immediately after reset, each doing a single transfer and then dropping `cyc`. Required: grant order 3'b001, 3'b010, 3'b100, then 3'b001 again if m0 is still requesting. There is one idle cycle between each owner.
3. m0 runs a 4-beat `cti`=010, `bte`=00 burst while m2 requests throughout. Required: m0 keeps the grant for all 4 acks; m2 is granted 2 cycles after m0 drops `cyc`; `m_ack_o[2]` stays 0 during the burst.
4. `timeout`=8 and the slave never acks m1. Required: `m_err_o`=3'b010 and `timeout_o`=1 on the 8th stb cycle, with `s_stb_o`=0 in that cycle.
5. Same as scenario 4, but `s_ack_i`=1 on exactly the 8th cycle. Required: `m_ack_o[1]`=1, `m_err_o`=0, `timeout_o`=0.
6. `wb_rst_ni`=0 mid-burst for one cycle. Required: `s_cyc_o`=0 and `grant_o`=0 next cycle, all terminations 0, and master 0 has priority afterwards.

Source files
------------

// File: rtl/wb_mem_arbiter.sv
// Round-robin Wishbone B3 arbiter sharing one RAM slave among several masters.
// Ownership lasts for a whole cyc; a per-transfer watchdog ends hung accesses with err.
module wb_mem_arbiter #(
    parameter int         num_masters = 3,
    parameter int         aw          = 32,
    parameter int         dw          = 32,
    parameter logic [7:0] timeout     = 8'd255
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_ni,
    input  logic [num_masters*aw-1:0]   m_adr_i,
    input  logic [num_masters*dw-1:0]   m_dat_i,
    input  logic [num_masters*dw/8-1:0] m_sel_i,
    input  logic [num_masters-1:0]      m_we_i,
    input  logic [num_masters-1:0]      m_cyc_i,
    input  logic [num_masters-1:0]      m_stb_i,
    input  logic [num_masters*3-1:0]    m_cti_i,
    input  logic [num_masters*2-1:0]    m_bte_i,
    output logic [dw-1:0]               m_dat_o,
    output logic [num_masters-1:0]      m_ack_o,
    output logic [num_masters-1:0]      m_err_o,
    output logic [num_masters-1:0]      m_rty_o,
    output logic [aw-1:0]               s_adr_o,
    output logic [dw-1:0]               s_dat_o,
    output logic [dw/8-1:0]             s_sel_o,
    output logic                        s_we_o,
    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    output logic [2:0]                  s_cti_o,
    output logic [1:0]                  s_bte_o,
    input  logic [dw-1:0]               s_dat_i,
    input  logic                        s_ack_i,
    input  logic                        s_err_i,
    input  logic                        s_rty_i,
    output logic [num_masters-1:0]      grant_o,
    output logic                        timeout_o
);

    localparam int iw = (num_masters > 1) ? $clog2(num_masters) : 1;
    localparam int sw = dw / 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [num_masters-1:0]   grant_q, grant_d;
    logic [iw-1:0]            last_q, last_d;
    logic [7:0]               wd_q, wd_d;
    logic [iw-1:0]            pick_s;
    logic                     own_s;
    logic                     stb_raw_s;
    logic                     term_s;
    logic                     wd_fire_s;

    // First requester scanning upward from the index after the previous winner.
    function automatic logic [iw-1:0] rr_pick(input logic [num_masters-1:0] req,
                                              input logic [iw-1:0]          last);
        logic [iw-1:0] win;
        logic          found;
        int            idx;
        win   = last;
        found = 1'b0;
        for (int i = 1; i <= num_masters; i++) begin
            idx = (int'(last) + i) % num_masters;
            if (!found && req[idx]) begin
                win   = iw'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign pick_s = rr_pick(m_cyc_i, last_q);

    // State register; last_q doubles as the owner index while in OWN.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= iw'(num_masters - 1);
            wd_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

    // Next-state logic: grant on any request, release only when the owner drops cyc.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        wd_d    = 8'd0;
        case (state_q)
            IDLE: begin
                if (|m_cyc_i) begin
                    state_d         = OWN;
                    last_d          = pick_s;
                    grant_d         = '0;
                    grant_d[pick_s] = 1'b1;
                end else begin
                    grant_d = '0;
                end
            end
            OWN: begin
                if (!m_cyc_i[last_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else begin
                    state_d = OWN;
                end
                // Watchdog saturates rather than wrapping so a stall can never alias to zero.
                if (term_s || !stb_raw_s || wd_fire_s) begin
                    wd_d = 8'd0;
                end else if (wd_q != 8'hff) begin
                    wd_d = wd_q + 8'd1;
                end else begin
                    wd_d = wd_q;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Output logic: combinational mux from the registered owner, no pipeline stages.
    always_comb begin
        own_s     = (state_q == OWN);
        term_s    = s_ack_i | s_err_i | s_rty_i;
        stb_raw_s = own_s & m_stb_i[last_q];
        wd_fire_s = (timeout != 8'd0) && (wd_q == (timeout - 8'd1)) && stb_raw_s && !term_s;
        if (own_s) begin
            s_adr_o = m_adr_i[last_q*aw +: aw];
            s_dat_o = m_dat_i[last_q*dw +: dw];
            s_sel_o = m_sel_i[last_q*sw +: sw];
            s_we_o  = m_we_i[last_q];
            s_cti_o = m_cti_i[last_q*3 +: 3];
            s_bte_o = m_bte_i[last_q*2 +: 2];
            s_cyc_o = m_cyc_i[last_q];
        end else begin
            s_adr_o = '0;
            s_dat_o = '0;
            s_sel_o = '0;
            s_we_o  = 1'b0;
            s_cti_o = 3'b000;
            s_bte_o = 2'b00;
            s_cyc_o = 1'b0;
        end
        s_stb_o   = stb_raw_s & ~wd_fire_s;
        m_ack_o   = grant_q & {num_masters{s_ack_i}};
        m_err_o   = grant_q & {num_masters{s_err_i | wd_fire_s}};
        m_rty_o   = grant_q & {num_masters{s_rty_i}};
        m_dat_o   = s_dat_i;
        grant_o   = grant_q;
        timeout_o = wd_fire_s;
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: directed vector table for the arbitration/watchdog
// scenarios, then randomized traffic compared against a behavioural model.
module tb_wb_mem_arbiter;

    localparam int N = 3;
    localparam int T = 8;

    logic          clk;
    logic          rst_n;
    logic [95:0]   m_adr, m_dat;
    logic [11:0]   m_sel;
    logic [2:0]    m_we, m_cyc, m_stb;
    logic [8:0]    m_cti;
    logic [5:0]    m_bte;
    logic [31:0]   m_dat_o;
    logic [2:0]    m_ack_o, m_err_o, m_rty_o;
    logic [31:0]   s_adr_o, s_dat_o;
    logic [3:0]    s_sel_o;
    logic          s_we_o, s_cyc_o, s_stb_o;
    logic [2:0]    s_cti_o;
    logic [1:0]    s_bte_o;
    logic [31:0]   s_dat_i;
    logic          s_ack_i, s_err_i, s_rty_i;
    logic [2:0]    grant_o;
    logic          timeout_o;

    int n_chk  = 0;
    int n_pass = 0;

    // model state: owner index (-1 = nobody), last winner, watchdog count
    int own  = -1;
    int last = N - 1;
    int wd   = 0;

    typedef struct {
        bit       rst_n;
        bit [2:0] cyc;
        bit [2:0] stb;
        bit       ack;
        bit [2:0] e_grant;
        bit [2:0] e_ack;
        bit [2:0] e_err;
        bit       e_scyc;
        bit       e_sstb;
        bit       e_to;
    } vec_t;

    vec_t vq[$];

    wb_mem_arbiter #(.num_masters(N), .aw(32), .dw(32), .timeout(8'd8)) dut (
        .wb_clk_i (clk),     .wb_rst_ni(rst_n),
        .m_adr_i  (m_adr),   .m_dat_i  (m_dat),   .m_sel_i (m_sel),
        .m_we_i   (m_we),    .m_cyc_i  (m_cyc),   .m_stb_i (m_stb),
        .m_cti_i  (m_cti),   .m_bte_i  (m_bte),
        .m_dat_o  (m_dat_o), .m_ack_o  (m_ack_o), .m_err_o (m_err_o), .m_rty_o(m_rty_o),
        .s_adr_o  (s_adr_o), .s_dat_o  (s_dat_o), .s_sel_o (s_sel_o),
        .s_we_o   (s_we_o),  .s_cyc_o  (s_cyc_o), .s_stb_o (s_stb_o),
        .s_cti_o  (s_cti_o), .s_bte_o  (s_bte_o),
        .s_dat_i  (s_dat_i), .s_ack_i  (s_ack_i), .s_err_i (s_err_i), .s_rty_i(s_rty_i),
        .grant_o  (grant_o), .timeout_o(timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    endtask

    task automatic add(input bit r, input bit [2:0] c, input bit [2:0] s, input bit a,
                       input bit [2:0] eg, input bit [2:0] ea, input bit [2:0] ee,
                       input bit ec, input bit es, input bit et);
        vec_t v;
        v.rst_n = r; v.cyc = c; v.stb = s; v.ack = a;
        v.e_grant = eg; v.e_ack = ea; v.e_err = ee;
        v.e_scyc = ec; v.e_sstb = es; v.e_to = et;
        vq.push_back(v);
    endtask

    // One clock: compare outputs with current inputs, then advance the model at the edge.
    task automatic step(input bit use_vec, input vec_t v, input int row);
        logic [2:0]  eg, ea, ee, er;
        logic        ecyc, estb, eto, stbraw, term, fire, ewe;
        logic [31:0] eadr, edat;
        logic [3:0]  esel;
        logic [2:0]  ecti;
        logic [1:0]  ebte;
        @(negedge clk);
        eg = '0; ea = '0; ee = '0; er = '0;
        ecyc = 1'b0; estb = 1'b0; eto = 1'b0; stbraw = 1'b0; fire = 1'b0; ewe = 1'b0;
        eadr = '0; edat = '0; esel = '0; ecti = '0; ebte = '0;
        term = s_ack_i | s_err_i | s_rty_i;
        if (own >= 0) begin
            eg[own] = 1'b1;
            ecyc    = m_cyc[own];
            stbraw  = m_stb[own];
            fire    = (wd == T - 1) && stbraw && !term;
            estb    = stbraw && !fire;
            ea[own] = s_ack_i;
            ee[own] = s_err_i | fire;
            er[own] = s_rty_i;
            eto     = fire;
            eadr    = m_adr[own*32 +: 32];
            edat    = m_dat[own*32 +: 32];
            esel    = m_sel[own*4 +: 4];
            ewe     = m_we[own];
            ecti    = m_cti[own*3 +: 3];
            ebte    = m_bte[own*2 +: 2];
        end
        chk("grant", 64'(grant_o), 64'(eg));
        chk("m_ack", 64'(m_ack_o), 64'(ea));
        chk("m_err", 64'(m_err_o), 64'(ee));
        chk("m_rty", 64'(m_rty_o), 64'(er));
        chk("s_cyc", 64'(s_cyc_o), 64'(ecyc));
        chk("s_stb", 64'(s_stb_o), 64'(estb));
        chk("timeout", 64'(timeout_o), 64'(eto));
        chk("s_adr", 64'(s_adr_o), 64'(eadr));
        chk("s_dat", 64'(s_dat_o), 64'(edat));
        chk("s_sel", 64'(s_sel_o), 64'(esel));
        chk("s_we", 64'(s_we_o), 64'(ewe));
        chk("s_cti", 64'(s_cti_o), 64'(ecti));
        chk("s_bte", 64'(s_bte_o), 64'(ebte));
        chk("m_dat", 64'(m_dat_o), 64'(s_dat_i));
        if (use_vec) begin
            chk($sformatf("vec%0d_grant", row), 64'(grant_o), 64'(v.e_grant));
            chk($sformatf("vec%0d_ack", row), 64'(m_ack_o), 64'(v.e_ack));
            chk($sformatf("vec%0d_err", row), 64'(m_err_o), 64'(v.e_err));
            chk($sformatf("vec%0d_scyc", row), 64'(s_cyc_o), 64'(v.e_scyc));
            chk($sformatf("vec%0d_sstb", row), 64'(s_stb_o), 64'(v.e_sstb));
            chk($sformatf("vec%0d_to", row), 64'(timeout_o), 64'(v.e_to));
        end
        @(posedge clk);
        if (!rst_n) begin
            own = -1; last = N - 1; wd = 0;
        end else if (own < 0) begin
            wd = 0;
            for (int i = 1; i <= N; i++) begin
                int c;
                c = (last + i) % N;
                if (m_cyc[c]) begin
                    own = c; last = c;
                    break;
                end
            end
        end else begin
            if (term || !stbraw || fire) wd = 0;
            else if (wd < 255) wd++;
            if (!m_cyc[own]) own = -1;
        end
        #1;
    endtask

    initial begin
        vec_t dummy;
        int   ack_rate;
        dummy = '{default: '0};

        rst_n   = 1'b0;
        m_adr   = {32'h0000_0200, 32'h0000_0100, 32'h0000_0000};
        m_dat   = {32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};
        m_sel   = 12'hFFF;
        m_we    = 3'b010;
        m_cyc   = 3'b000;
        m_stb   = 3'b000;
        m_cti   = {3'b000, 3'b010, 3'b010};
        m_bte   = 6'b00_00_00;
        s_dat_i = 32'hCAFE_F00D;
        s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // single write from m1
        add(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b010, 3'b010, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b010, 3'b010, 1'b0, 3'b010, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 3'b010, 3'b010, 1'b1, 3'b010, 3'b010, 3'b000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 3'b000, 3'b000, 1'b0, 3'b010, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        // three simultaneous requesters after reset
        add(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b111, 3'b111, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b111, 3'b111, 1'b1, 3'b001, 3'b001, 3'b000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 3'b110, 3'b110, 1'b0, 3'b001, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b110, 3'b110, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b110, 3'b110, 1'b1, 3'b010, 3'b010, 3'b000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 3'b101, 3'b101, 1'b0, 3'b010, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b101, 3'b101, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b101, 3'b101, 1'b1, 3'b100, 3'b100, 3'b000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 3'b001, 3'b001, 1'b0, 3'b100, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b001, 3'b001, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b001, 3'b001, 1'b1, 3'b001, 3'b001, 3'b000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 3'b000, 3'b000, 1'b0, 3'b001, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        // m0 4-beat burst with m2 waiting
        add(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b101, 3'b101, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b101, 3'b101, 1'b0, 3'b001, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0);
        repeat (4) add(1'b1, 3'b101, 3'b101, 1'b1, 3'b001, 3'b001, 3'b000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 3'b100, 3'b100, 1'b0, 3'b001, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b100, 3'b100, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b100, 3'b100, 1'b1, 3'b100, 3'b100, 3'b000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 3'b000, 3'b000, 1'b0, 3'b100, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        // watchdog fires on the 8th unanswered strobe
        add(1'b1, 3'b010, 3'b010, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        repeat (7) add(1'b1, 3'b010, 3'b010, 1'b0, 3'b010, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 3'b010, 3'b010, 1'b0, 3'b010, 3'b000, 3'b010, 1'b1, 1'b0, 1'b1);
        add(1'b1, 3'b000, 3'b000, 1'b0, 3'b010, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        // ack exactly at the limit wins over the watchdog
        add(1'b1, 3'b010, 3'b010, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        repeat (7) add(1'b1, 3'b010, 3'b010, 1'b0, 3'b010, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 3'b010, 3'b010, 1'b1, 3'b010, 3'b010, 3'b000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 3'b000, 3'b000, 1'b0, 3'b010, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        // reset in the middle of an m1 burst, then m0 must win
        add(1'b1, 3'b010, 3'b010, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b010, 3'b010, 1'b1, 3'b010, 3'b010, 3'b000, 1'b1, 1'b1, 1'b0);
        add(1'b0, 3'b010, 3'b010, 1'b1, 3'b010, 3'b010, 3'b000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 3'b111, 3'b111, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b111, 3'b111, 1'b0, 3'b001, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 3'b000, 3'b000, 1'b0, 3'b001, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

        foreach (vq[i]) begin
            rst_n   = vq[i].rst_n;
            m_cyc   = vq[i].cyc;
            m_stb   = vq[i].stb;
            s_ack_i = vq[i].ack;
            s_err_i = 1'b0;
            s_rty_i = 1'b0;
            step(1'b1, vq[i], i);
        end

        // randomized traffic, slave responsiveness varies in phases to reach the watchdog
        ack_rate = 3;
        for (int cyc_n = 0; cyc_n < 4000; cyc_n++) begin
            if (cyc_n % 64 == 0) ack_rate = $urandom_range(0, 4);
            rst_n = ($urandom_range(0, 199) != 0);
            for (int k = 0; k < N; k++) begin
                if (m_cyc[k]) begin
                    if ($urandom_range(0, 5) == 0) m_cyc[k] = 1'b0;
                end else begin
                    if ($urandom_range(0, 3) == 0) m_cyc[k] = 1'b1;
                end
            end
            m_stb   = m_cyc & 3'($urandom_range(0, 7) | $urandom_range(0, 7));
            m_adr   = {$urandom, $urandom, $urandom};
            m_dat   = {$urandom, $urandom, $urandom};
            m_sel   = 12'($urandom);
            m_we    = 3'($urandom);
            m_cti   = 9'($urandom);
            m_bte   = 6'($urandom);
            s_dat_i = $urandom;
            s_ack_i = ($urandom_range(0, 9) < ack_rate);
            s_err_i = (ack_rate != 0) && ($urandom_range(0, 29) == 0);
            s_rty_i = (ack_rate != 0) && ($urandom_range(0, 29) == 0);
            step(1'b0, dummy, cyc_n);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
